car_motion_ctrl: RTL and testbench

- Game-logic controller for the VGA car demo. Once per video frame it sequences the car sprite's X position, velocity, lives and game state.
- Sits between the player button inputs (ui_in) and the sprite renderer. The renderer consumes car_x, flash and state. frame_tick comes from the hvsync generator at the start of vertical blanking.

---
 rtl/car_motion_ctrl.sv | 178 +++++++++++++++++
 tb/tb_car_motion_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/car_motion_ctrl.sv
// Per-frame game logic for the VGA car demo: button sync, car position/velocity,
// lives and IDLE/RUN/CRASH/GAMEOVER sequencing. All outputs registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; car parked at START_X
// RUN      | player steering; obstacle_hit costs a life
// CRASH    | car frozen and blinking for CRASH_FRAMES frames, then respawn
// GAMEOVER | no lives left; car shown steady-hidden until start
module car_motion_ctrl #(
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 600,
    parameter int START_X      = 100,
    parameter int MAX_SPEED    = 6,
    parameter int CRASH_FRAMES = 64,
    parameter int LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       obstacle_hit,
    output logic [9:0] car_x,
    output logic [4:0] velocity,
    output logic [1:0] lives,
    output logic [1:0] state,
    output logic       flash
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        CRASH    = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [5:0]  MAX_POS    = 6'(MAX_SPEED);
    localparam logic signed [5:0]  MAX_NEG    = -6'(MAX_SPEED);
    localparam logic [7:0]         CRASH_LAST = 8'(CRASH_FRAMES - 1);

    state_t             st;
    logic               left_s1, left_s2, right_s1, right_s2;
    logic               start_s1, start_s2, start_prev;
    logic               start_pending;
    logic               start_rise;
    logic               start_go;
    logic [7:0]         crash_cnt;
    logic [7:0]         crash_inc;
    logic signed [5:0]  dir;
    logic signed [5:0]  vel_ext;
    logic signed [5:0]  v_sum;
    logic signed [4:0]  v_new;
    logic signed [10:0] nx;

    assign state      = st;
    assign start_rise = start_s2 & ~start_prev;
    // A rise landing on the tick cycle itself still counts.
    assign start_go   = start_pending | start_rise;
    assign crash_inc  = crash_cnt + 8'd1;

    always_comb begin
        dir = 6'sd0;
        if (right_s2 && !left_s2)
            dir = 6'sd1;
        else if (left_s2 && !right_s2)
            dir = -6'sd1;
        vel_ext = {velocity[4], velocity};
        v_sum   = vel_ext + dir;
        v_new   = v_sum[4:0];
        if (dir == 6'sd0) begin
            if (vel_ext > 6'sd0)
                v_new = 5'(vel_ext - 6'sd1);
            else if (vel_ext < 6'sd0)
                v_new = 5'(vel_ext + 6'sd1);
            else
                v_new = 5'sd0;
        end else if (v_sum > MAX_POS) begin
            v_new = 5'(MAX_POS);
        end else if (v_sum < MAX_NEG) begin
            v_new = 5'(MAX_NEG);
        end
        nx = $signed({1'b0, car_x}) + $signed({{6{v_new[4]}}, v_new});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_s1       <= 1'b0;
            left_s2       <= 1'b0;
            right_s1      <= 1'b0;
            right_s2      <= 1'b0;
            start_s1      <= 1'b0;
            start_s2      <= 1'b0;
            start_prev    <= 1'b0;
            start_pending <= 1'b0;
            crash_cnt     <= 8'd0;
            st            <= IDLE;
            car_x         <= 10'(START_X);
            velocity      <= 5'd0;
            lives         <= 2'(LIVES_INIT);
            flash         <= 1'b0;
        end else begin
            left_s1    <= btn_left;
            left_s2    <= left_s1;
            right_s1   <= btn_right;
            right_s2   <= right_s1;
            start_s1   <= btn_start;
            start_s2   <= start_s1;
            start_prev <= start_s2;

            if (frame_tick)
                start_pending <= 1'b0;
            else if (start_rise)
                start_pending <= 1'b1;

            if (frame_tick) begin
                case (st)
                    IDLE: begin
                        car_x    <= 10'(START_X);
                        velocity <= 5'd0;
                        flash    <= 1'b0;
                        if (start_go) begin
                            st    <= RUN;
                            lives <= 2'(LIVES_INIT);
                        end
                    end
                    RUN: begin
                        if (obstacle_hit) begin
                            if (lives != 2'd0)
                                lives <= lives - 2'd1;
                            if (lives <= 2'd1) begin
                                st    <= GAMEOVER;
                                flash <= 1'b1;
                            end else begin
                                st        <= CRASH;
                                crash_cnt <= 8'd0;
                            end
                        end else if (nx < X_MIN_S) begin
                            car_x    <= 10'(X_MIN);
                            velocity <= 5'd0;
                        end else if (nx > X_MAX_S) begin
                            car_x    <= 10'(X_MAX);
                            velocity <= 5'd0;
                        end else begin
                            car_x    <= nx[9:0];
                            velocity <= v_new;
                        end
                    end
                    CRASH: begin
                        if (crash_cnt == CRASH_LAST) begin
                            st       <= RUN;
                            car_x    <= 10'(START_X);
                            velocity <= 5'd0;
                            flash    <= 1'b0;
                        end else begin
                            crash_cnt <= crash_inc;
                            flash     <= crash_inc[3];
                        end
                    end
                    GAMEOVER: begin
                        flash <= 1'b1;
                        if (start_go) begin
                            st       <= IDLE;
                            car_x    <= 10'(START_X);
                            velocity <= 5'd0;
                            flash    <= 1'b0;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: directed game scenarios plus randomized play,
// checked frame by frame against an integer game model.
module tb_car_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_start = 1'b0;
    logic       obstacle_hit = 1'b0;
    logic [9:0] car_x;
    logic [4:0] velocity;
    logic [1:0] lives;
    logic [1:0] state;
    logic       flash;

    int n_chk  = 0;
    int n_fail = 0;
    int n_frame = 0;

    // game model
    int m_x, m_v, m_lives, m_state, m_cnt, m_flash, m_pending;

    car_motion_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_start    (btn_start),
        .obstacle_hit (obstacle_hit),
        .car_x        (car_x),
        .velocity     (velocity),
        .lives        (lives),
        .state        (state),
        .flash        (flash)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (frame %0d): observed %0d expected %0d", tag, n_frame, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("car_x",    {22'd0, car_x},    32'(m_x));
        chk("velocity", {27'd0, velocity}, 32'(m_v & 31));
        chk("lives",    {30'd0, lives},    32'(m_lives));
        chk("state",    {30'd0, state},    32'(m_state));
        chk("flash",    {31'd0, flash},    32'(m_flash));
    endtask

    task automatic model_reset();
        m_x = 100; m_v = 0; m_lives = 3; m_state = 0;
        m_cnt = 0; m_flash = 0; m_pending = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit h);
        int d;
        int nx;
        case (m_state)
            0: begin
                m_x = 100; m_v = 0; m_flash = 0;
                if (m_pending != 0) begin
                    m_state = 1;
                    m_lives = 3;
                end
            end
            1: begin
                if (h) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    if (m_lives == 0) begin
                        m_state = 3;
                        m_flash = 1;
                    end else begin
                        m_state = 2;
                        m_cnt = 0;
                    end
                end else begin
                    d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
                    if (d != 0) begin
                        m_v = m_v + d;
                        if (m_v > 6) m_v = 6;
                        if (m_v < -6) m_v = -6;
                    end else if (m_v > 0) begin
                        m_v = m_v - 1;
                    end else if (m_v < 0) begin
                        m_v = m_v + 1;
                    end
                    nx = m_x + m_v;
                    if (nx < 0) begin
                        m_x = 0; m_v = 0;
                    end else if (nx > 600) begin
                        m_x = 600; m_v = 0;
                    end else begin
                        m_x = nx;
                    end
                end
            end
            2: begin
                if (m_cnt == 63) begin
                    m_state = 1; m_x = 100; m_v = 0; m_flash = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                    m_flash = (m_cnt / 8) % 2;
                end
            end
            default: begin
                m_flash = 1;
                if (m_pending != 0) begin
                    m_state = 0; m_x = 100; m_v = 0; m_flash = 0;
                end
            end
        endcase
        m_pending = 0;
    endtask

    task automatic frame(input bit l, input bit r, input bit h);
        btn_left = l;
        btn_right = r;
        obstacle_hit = h;
        repeat (4) @(negedge clk);
        chk("hold_car_x", {22'd0, car_x}, 32'(m_x));
        chk("hold_state", {30'd0, state}, 32'(m_state));
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        obstacle_hit = 1'b0;
        n_frame++;
        model_frame(l, r, h);
        check_all();
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        repeat (4) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        m_pending = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        obstacle_hit = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Tick without start stays in IDLE
        frame(0, 0, 0);
        chk("idle_no_start", {30'd0, state}, 32'd0);

        press_start();
        frame(0, 0, 0);
        chk("start_to_run", {30'd0, state}, 32'd1);

        // Acceleration, saturation, decay
        for (int i = 0; i < 8; i++) frame(0, 1, 0);
        chk("accel_x", {22'd0, car_x}, 32'd133);
        for (int i = 0; i < 6; i++) frame(0, 0, 0);
        chk("decay_x", {22'd0, car_x}, 32'd148);
        for (int i = 0; i < 3; i++) frame(0, 1, 0);
        for (int i = 0; i < 4; i++) frame(1, 1, 0);
        chk("both_decay_v", {27'd0, velocity}, 32'd0);

        // Walls
        for (int i = 0; i < 120; i++) frame(0, 1, 0);
        chk("right_wall", {22'd0, car_x}, 32'd600);
        for (int i = 0; i < 150; i++) frame(1, 0, 0);
        chk("left_wall", {22'd0, car_x}, 32'd0);

        // Crash, ignored hits during crash, respawn
        frame(0, 1, 1);
        chk("crash_state", {30'd0, state}, 32'd2);
        chk("crash_lives", {30'd0, lives}, 32'd2);
        for (int i = 0; i < 64; i++)
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i % 5) == 0);
        chk("respawn_state", {30'd0, state}, 32'd1);
        chk("respawn_x", {22'd0, car_x}, 32'd100);
        chk("respawn_lives", {30'd0, lives}, 32'd2);

        frame(0, 0, 1);
        for (int i = 0; i < 64; i++) frame(0, 1, 0);
        frame(0, 0, 1);
        chk("gameover_state", {30'd0, state}, 32'd3);
        chk("gameover_lives", {30'd0, lives}, 32'd0);
        chk("gameover_flash", {31'd0, flash}, 32'd1);
        frame(0, 1, 1);

        // Start presses: GAMEOVER -> IDLE -> RUN
        press_start();
        frame(0, 0, 0);
        chk("go_to_idle", {30'd0, state}, 32'd0);
        press_start();
        frame(0, 0, 0);
        chk("restart_run", {30'd0, state}, 32'd1);
        chk("restart_lives", {30'd0, lives}, 32'd3);

        // Start in RUN is discarded
        press_start();
        frame(0, 1, 0);
        frame(0, 0, 1);
        for (int i = 0; i < 20; i++) frame(0, 0, 0);

        // Reset in mid-crash
        do_reset();
        chk("mid_crash_reset_state", {30'd0, state}, 32'd0);

        // Randomized play
        press_start();
        frame(0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) press_start();
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
